// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, port ids and width defaults for mem_arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational two-way picker, round-robin on ties
// ARB_DCACHE_PRIORITY_EN: D-cache always wins ties instead.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic winner
);

  logic w_tie_pick;

`ifdef ARB_DCACHE_PRIORITY_EN
  // last is still tracked by the top but cannot influence a tie here
  assign w_tie_pick = last | PORT_D;
`else
  assign w_tie_pick = ~last;
`endif

  always_comb begin
    winner = PORT_I;
    if (req_i && req_d) begin
      winner = w_tie_pick;
    end else if (req_d) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-transaction I/D cache arbiter for the shared off-chip memory
// Tie policy is selected in arb_rr2 by ARB_DCACHE_PRIORITY_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              r_state;
  logic                r_last;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_req_i;
  logic                w_req_d;
  logic                w_winner;

  assign w_req_i = ic_read;
  assign w_req_d = dc_read | dc_write;

  arb_rr2 u_arb (
    .req_i  (w_req_i),
    .req_d  (w_req_d),
    .last   (r_last),
    .winner (w_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last      <= PORT_D;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_i || w_req_d) begin
            r_last <= w_winner;
            if (w_winner == PORT_D) begin
              // write wins if the D-cache raises both commands
              r_state     <= BUSY_D;
              r_mem_read  <= ~dc_write;
              r_mem_write <= dc_write;
              r_mem_addr  <= dc_addr;
              if (dc_write) begin
                r_mem_wdata <= dc_wdata;
              end
            end else begin
              r_state     <= BUSY_I;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
              r_mem_addr  <= ic_addr;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // completion is routed to the owner in the same cycle memory signals it
  assign ic_ready = (r_state == BUSY_I) && mem_ready;
  assign dc_ready = (r_state == BUSY_D) && mem_ready;
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single off-chip memory between the I-cache (read-only) and the D-cache (read/write) in the cached pipelined processor. It holds one transaction at a time, registers the memory-side request, and routes the memory response back to the owning cache. It sits between both cache miss/write-back FSMs and the slow memory model, which has an unbounded ready latency.

## Interface
- ADDR_W, 28, block address width (word address >> 2, 128-bit lines)
- DATA_W, 128, line width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- ic_read  in  1  I-cache line-fill request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache line address
- ic_rdata  out  DATA_W  fill data, valid with ic_ready
- ic_ready  out  1  one-cycle completion strobe to I-cache
- dc_read  in  1  D-cache line-fill request, held until dc_ready
- dc_write  in  1  D-cache write-back request, held until dc_ready
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  DATA_W  write-back data
- dc_rdata  out  DATA_W  fill data, valid with dc_ready
- dc_ready  out  1  one-cycle completion strobe to D-cache
- mem_read  out  1  memory read command, registered
- mem_write  out  1  memory write command, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion strobe, one cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if any request is high at a rising edge, pick a winner, move to BUSY_I/BUSY_D, and latch mem_read/mem_write/mem_addr/mem_wdata from the winner at that edge. With no request, stay in IDLE.
- Arbitration: two-way round-robin. A pointer `last` records the most recently granted port. When both ports request, the port other than `last` wins. When one port requests, it wins. `last` updates on every grant.
- D-cache command: dc_write takes precedence if dc_read and dc_write are both high (illegal case). mem_wdata is loaded only for writes; otherwise it holds its old value.
- BUSY_x: the memory-side registers stay stable. Requester inputs are ignored, including changes to the owner's address.
- On mem_ready in BUSY_x:
  - x_ready = 1 combinationally in the same cycle.
  - x_rdata = mem_rdata as a passthrough.
  - At that edge, mem_read/mem_write clear to 0 and the state returns to IDLE.
- The non-owner's ready is always 0. ic_rdata and dc_rdata both pass mem_rdata unconditionally and are qualified only by ready.
- mem_ready in IDLE is ignored: no ready output, no state change.
- A request seen in IDLE right after completion is treated as new, e.g. a D-cache write-back followed by an allocate read.

## Timing
- Reset values:
  - state IDLE, `last` = D, so the I-cache wins the first tie.
  - mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - ic_ready = dc_ready = 0.
- Grant latency: request high at edge N → mem_read/mem_write high from cycle N+1.
- Completion: mem_ready in cycle M → x_ready in cycle M. The command drops at edge M+1, and there is one IDLE cycle before the next grant.
- Minimum turnaround: 1 IDLE cycle between transactions. Back-to-back ties alternate I, D, I, D…
- Reset mid-transaction: immediately returns to the reset values. A late mem_ready after reset is ignored, because the state is IDLE.
- Requesters must hold request, address, and data until their ready strobe. The arbiter does not check this.

## Configuration
- ARB_DCACHE_PRIORITY_EN
  - Defined: fixed priority, the D-cache always wins ties. `last` still updates but has no effect.
  - Undefined: round-robin as above.
- Single-requester behaviour and timing are identical in both builds.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2)
  - port IDs (PORT_I = 1'b0, PORT_D = 1'b1)
  - defaults for ADDR_W and DATA_W
- One sub-module, `arb_rr2`: purely combinational two-way picker with inputs req_i, req_d, last and output winner. It contains the ARB_DCACHE_PRIORITY_EN branch.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, no command issued; a stray mem_ready pulse produces no ic_ready or dc_ready.
- ic_read, ic_addr = 28'h0000010, memory ready after 4 cycles with rdata = 128'hA5…A5:
  - mem_read high 1 cycle after the request, mem_addr = 28'h0000010
  - ic_ready and ic_rdata = 128'hA5…A5 in the ready cycle
  - mem_read low the next cycle
- ic_read and dc_write raised together in the same cycle, then held:
  - round-robin build: I served first, then D with mem_write = 1 and mem_wdata = dc_wdata
  - ARB_DCACHE_PRIORITY_EN build: D first
- Both ports request continuously for 6 transactions (round-robin build) → grant order I, D, I, D, I, D, with exactly one IDLE cycle between completions.
- D write-back to 28'h0000020 followed immediately by a D read from 28'h0000030 while ic_read is pending:
  - after the write completes, I wins the next grant
  - then the D read issues
- rst pulled low during BUSY_D, before mem_ready → mem_write = 0 immediately; a late mem_ready after release yields no dc_ready; the next request is granted normally.
